// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: LSTM timestep sequencer holding recurrent h state, firing the cell array, and keeping an h/c history buffer
module lstm_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int NUM      = 68,
    parameter int NUM_LSTM = 8,
    parameter int SEQ_MAX  = 16,
    parameter int LEN_W    = 5,
    parameter int CELL_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [LEN_W-1:0]                 i_seq_len,
    input  logic                             i_abort,
    input  logic                             i_x_valid,
    input  logic [NUM*WIDTH-1:0]             i_x,
    output logic                             o_x_ready,
    output logic [(NUM+NUM_LSTM)*WIDTH-1:0]  o_c_x,
    output logic                             o_sel,
    output logic                             o_cell_en,
    input  logic [NUM_LSTM*WIDTH-1:0]        i_h,
    input  logic [NUM_LSTM*WIDTH-1:0]        i_c,
    output logic                             o_h_valid,
    output logic [NUM_LSTM*WIDTH-1:0]        o_h,
    output logic [LEN_W-1:0]                 o_t,
    input  logic                             i_h_ready,
    output logic                             o_busy,
    output logic                             o_done,
    input  logic [LEN_W-1:0]                 i_rd_addr,
    output logic [NUM_LSTM*WIDTH-1:0]        o_rd_h,
    output logic [NUM_LSTM*WIDTH-1:0]        o_rd_c
);
    localparam int HW = NUM_LSTM * WIDTH;
    localparam int AW = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int CW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_X, COMPUTE, OUTPUT, DONE} state_t;

    state_t                          state_q;
    logic [HW-1:0]                   h_prev_q;
    logic [HW-1:0]                   h_q;
    logic [HW-1:0]                   rd_h_q;
    logic [HW-1:0]                   rd_c_q;
    logic [(NUM+NUM_LSTM)*WIDTH-1:0] c_x_q;
    logic [LEN_W-1:0]                t_q;
    logic [LEN_W-1:0]                len_q;
    logic [LEN_W-1:0]                len_d;
    logic [CW-1:0]                   cnt_q;
    logic                            x_ready_q;
    logic                            sel_q;
    logic                            cell_en_q;
    logic                            h_valid_q;
    logic                            done_q;
    logic                            last_cyc;
    logic                            hist_we;
    logic [HW-1:0]                   hist_h [SEQ_MAX];
    logic [HW-1:0]                   hist_c [SEQ_MAX];

    assign len_d    = (i_seq_len > LEN_W'(SEQ_MAX)) ? LEN_W'(SEQ_MAX) : i_seq_len;
    assign last_cyc = (state_q == COMPUTE) && (cnt_q == CW'(CELL_LAT - 1));
    assign hist_we  = last_cyc && !i_abort;

    assign o_x_ready = x_ready_q;
    assign o_c_x     = c_x_q;
    assign o_sel     = sel_q;
    assign o_cell_en = cell_en_q;
    assign o_h_valid = h_valid_q;
    assign o_h       = h_q;
    assign o_t       = t_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_rd_h    = rd_h_q;
    assign o_rd_c    = rd_c_q;

    // Sequencer: abort wins over every handshake; outputs are registered alongside state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            h_prev_q  <= '0;
            h_q       <= '0;
            c_x_q     <= '0;
            t_q       <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            x_ready_q <= 1'b0;
            sel_q     <= 1'b0;
            cell_en_q <= 1'b0;
            h_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (i_abort && state_q != IDLE) begin
            state_q   <= IDLE;
            h_prev_q  <= '0;
            t_q       <= '0;
            x_ready_q <= 1'b0;
            cell_en_q <= 1'b0;
            h_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cell_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        len_q    <= len_d;
                        h_prev_q <= '0;
                        t_q      <= '0;
                        if (len_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= WAIT_X;
                            x_ready_q <= 1'b1;
                        end
                    end
                end
                WAIT_X: begin
                    if (i_x_valid) begin
                        c_x_q     <= {h_prev_q, i_x};
                        sel_q     <= (t_q != '0);
                        x_ready_q <= 1'b0;
                        cell_en_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (last_cyc) begin
                        h_prev_q  <= i_h;
                        h_q       <= i_h;
                        h_valid_q <= 1'b1;
                        state_q   <= OUTPUT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                OUTPUT: begin
                    if (i_h_ready) begin
                        h_valid_q <= 1'b0;
                        if (t_q == len_q - LEN_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            t_q       <= t_q + LEN_W'(1);
                            state_q   <= WAIT_X;
                            x_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // History storage: written on the final compute cycle, contents not reset
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_h[t_q[AW-1:0]] <= i_h;
            hist_c[t_q[AW-1:0]] <= i_c;
        end
    end

    // Registered read-first history port; out-of-range addresses read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_h_q <= '0;
            rd_c_q <= '0;
        end else begin
            rd_h_q <= (i_rd_addr < LEN_W'(SEQ_MAX)) ? hist_h[i_rd_addr[AW-1:0]] : '0;
            rd_c_q <= (i_rd_addr < LEN_W'(SEQ_MAX)) ? hist_c[i_rd_addr[AW-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: bench for lstm_seq_ctrl with a latency-gated stub cell array
module tb_lstm_seq_ctrl;
    localparam int WIDTH = 32, NUM = 68, NUM_LSTM = 8, SEQ_MAX = 16, LEN_W = 5, CELL_LAT = 2;
    localparam int HW = NUM_LSTM * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0, i_abort = 1'b0, i_x_valid = 1'b0, i_h_ready = 1'b0;
    logic [LEN_W-1:0] i_seq_len = '0, i_rd_addr = '0;
    logic [NUM*WIDTH-1:0] i_x = '0;
    logic [HW-1:0] i_h, i_c, o_h, o_rd_h, o_rd_c;
    logic [(NUM+NUM_LSTM)*WIDTH-1:0] o_c_x;
    logic o_x_ready, o_sel, o_cell_en, o_h_valid, o_busy, o_done;
    logic [LEN_W-1:0] o_t;

    int total = 0, bad = 0;
    int since = 0;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [7:0] abort_at;
        logic [2:0][31:0] x;
        logic [2:0][7:0] stall;
        logic [2:0][31:0] exp;
    } run_t;
    typedef struct packed {
        logic [LEN_W-1:0] addr;
        logic [31:0] h;
        logic [31:0] c;
    } rd_t;

    run_t runs[4];
    rd_t rdv[5];
    logic [31:0] seq_x[SEQ_MAX], seq_exp[SEQ_MAX];
    int seq_stall[SEQ_MAX], seq_gap[SEQ_MAX];
    logic [31:0] mh[SEQ_MAX], mc[SEQ_MAX];
    bit mw[SEQ_MAX];

    always #5 clk = ~clk;

    lstm_seq_ctrl #(.WIDTH(WIDTH), .NUM(NUM), .NUM_LSTM(NUM_LSTM), .SEQ_MAX(SEQ_MAX),
                    .LEN_W(LEN_W), .CELL_LAT(CELL_LAT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_seq_len(i_seq_len), .i_abort(i_abort),
        .i_x_valid(i_x_valid), .i_x(i_x), .o_x_ready(o_x_ready), .o_c_x(o_c_x), .o_sel(o_sel),
        .o_cell_en(o_cell_en), .i_h(i_h), .i_c(i_c), .o_h_valid(o_h_valid), .o_h(o_h), .o_t(o_t),
        .i_h_ready(i_h_ready), .o_busy(o_busy), .o_done(o_done), .i_rd_addr(i_rd_addr),
        .o_rd_h(o_rd_h), .o_rd_c(o_rd_c)
    );

    // Stub cell: results are only correct CELL_LAT-1 cycles after the fire pulse
    always @(posedge clk) since <= o_cell_en ? 1 : ((since == 0 || since > 7) ? since : since + 1);

    always_comb begin
        logic [31:0] hv;
        i_h = '0;
        i_c = '0;
        for (int k = 0; k < NUM_LSTM; k++) begin
            hv = (since == CELL_LAT - 1) ? o_c_x[WIDTH-1:0] + o_c_x[NUM*WIDTH + k*WIDTH +: WIDTH]
                                         : 32'hBAD0_0000 + 32'(k);
            i_h[k*WIDTH +: WIDTH] = hv;
            i_c[k*WIDTH +: WIDTH] = hv << 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fill_rand(input int n);
        logic [31:0] acc;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            seq_x[i] = $urandom_range(0, 1000);
            acc += seq_x[i];
            seq_exp[i] = acc;
            seq_stall[i] = $urandom_range(0, 3);
            seq_gap[i] = $urandom_range(0, 2);
        end
    endtask

    task automatic run_seq(input int len, input int abort_at);
        int n;
        logic [31:0] prev;
        n = (len > SEQ_MAX) ? SEQ_MAX : len;
        i_start = 1'b1;
        i_seq_len = LEN_W'(len);
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_start", o_busy, 1);
        if (n == 0) begin
            chk("done_len0", o_done, 1);
            chk("xrdy_len0", o_x_ready, 0);
            @(negedge clk);
            chk("done_len0_clr", o_done, 0);
            chk("busy_len0", o_busy, 0);
            return;
        end
        prev = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < seq_gap[i]; g++) begin
                chk("xrdy_gap", o_x_ready, 1);
                chk("hval_gap", o_h_valid, 0);
                i_start = 1'b1;
                i_seq_len = LEN_W'($urandom_range(0, 31));
                @(negedge clk);
                i_start = 1'b0;
            end
            chk("xrdy", o_x_ready, 1);
            chk("t_wait", o_t, i);
            for (int k = 0; k < NUM; k++) i_x[k*WIDTH +: WIDTH] = $urandom;
            i_x[WIDTH-1:0] = seq_x[i];
            i_x_valid = 1'b1;
            @(negedge clk);
            i_x_valid = 1'b0;
            chk("cell_en", o_cell_en, 1);
            chk("sel", o_sel, i != 0);
            chk("xrdy_low", o_x_ready, 0);
            chk("cx_x", o_c_x[WIDTH-1:0], seq_x[i]);
            for (int k = 0; k < NUM_LSTM; k++) chk("cx_hprev", o_c_x[NUM*WIDTH + k*WIDTH +: WIDTH], prev);
            for (int c = 1; c < CELL_LAT; c++) begin
                @(negedge clk);
                chk("cell_en_low", o_cell_en, 0);
                chk("hval_early", o_h_valid, 0);
            end
            if (i == abort_at) begin
                i_abort = 1'b1;
                @(negedge clk);
                i_abort = 1'b0;
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                chk("abort_hval", o_h_valid, 0);
                chk("abort_xrdy", o_x_ready, 0);
                chk("abort_t", o_t, 0);
                return;
            end
            @(negedge clk);
            chk("hval", o_h_valid, 1);
            chk("t_out", o_t, i);
            for (int k = 0; k < NUM_LSTM; k++) chk("h", o_h[k*WIDTH +: WIDTH], seq_exp[i]);
            for (int s = 0; s < seq_stall[i]; s++) begin
                @(negedge clk);
                chk("hval_stall", o_h_valid, 1);
                chk("h_stall", o_h[WIDTH-1:0], seq_exp[i]);
                chk("xrdy_stall", o_x_ready, 0);
            end
            i_h_ready = 1'b1;
            @(negedge clk);
            i_h_ready = 1'b0;
            chk("hval_clr", o_h_valid, 0);
            if (i == n - 1) chk("done", o_done, 1);
            else begin
                chk("done_mid", o_done, 0);
                chk("xrdy_next", o_x_ready, 1);
            end
            mh[i] = seq_exp[i];
            mc[i] = seq_exp[i] << 1;
            mw[i] = 1'b1;
            prev = seq_exp[i];
        end
        @(negedge clk);
        chk("done_clr", o_done, 0);
        chk("busy_end", o_busy, 0);
    endtask

    task automatic rd_chk(input logic [LEN_W-1:0] a, input logic [31:0] eh, input logic [31:0] ec);
        i_rd_addr = a;
        @(negedge clk);
        for (int k = 0; k < NUM_LSTM; k++) begin
            chk("rd_h", o_rd_h[k*WIDTH +: WIDTH], eh);
            chk("rd_c", o_rd_c[k*WIDTH +: WIDTH], ec);
        end
    endtask

    initial begin
        int len;
        runs[0] = '{len: 5'd3, abort_at: 8'd3, x: {32'd1, 32'd7, 32'd5}, stall: {8'd0, 8'd0, 8'd0}, exp: {32'd13, 32'd12, 32'd5}};
        runs[1] = '{len: 5'd3, abort_at: 8'd3, x: {32'd1, 32'd7, 32'd5}, stall: {8'd0, 8'd3, 8'd0}, exp: {32'd13, 32'd12, 32'd5}};
        runs[2] = '{len: 5'd3, abort_at: 8'd1, x: {32'd0, 32'd100, 32'd5}, stall: {8'd0, 8'd0, 8'd0}, exp: {32'd0, 32'd0, 32'd5}};
        runs[3] = '{len: 5'd2, abort_at: 8'd3, x: {32'd0, 32'd4, 32'd9}, stall: {8'd0, 8'd0, 8'd0}, exp: {32'd0, 32'd13, 32'd9}};
        rdv[0] = '{addr: 5'd0, h: 32'd5, c: 32'd10};
        rdv[1] = '{addr: 5'd1, h: 32'd12, c: 32'd24};
        rdv[2] = '{addr: 5'd2, h: 32'd13, c: 32'd26};
        rdv[3] = '{addr: 5'd16, h: 32'd0, c: 32'd0};
        rdv[4] = '{addr: 5'd31, h: 32'd0, c: 32'd0};
        for (int i = 0; i < SEQ_MAX; i++) mw[i] = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_xrdy", o_x_ready, 0);
        chk("rst_cx", o_c_x == '0, 1);
        chk("rst_sel", o_sel, 0);
        chk("rst_cell_en", o_cell_en, 0);
        chk("rst_hval", o_h_valid, 0);
        chk("rst_h", o_h == '0, 1);
        chk("rst_t", o_t, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rd", (o_rd_h == '0) && (o_rd_c == '0), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", o_busy, 0);
        i_x_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_xrdy", o_x_ready, 0);
            chk("idle_busy_v", o_busy, 0);
        end
        i_x_valid = 1'b0;

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                seq_x[i] = runs[r].x[i];
                seq_exp[i] = runs[r].exp[i];
                seq_stall[i] = int'(runs[r].stall[i]);
                seq_gap[i] = 0;
            end
            run_seq(int'(runs[r].len), int'(runs[r].abort_at));
            if (r == 1) for (int j = 0; j < 5; j++) rd_chk(rdv[j].addr, rdv[j].h, rdv[j].c);
            if (r == 2) rd_chk(5'd1, mh[1], mc[1]);
        end

        run_seq(0, -1);
        fill_rand(SEQ_MAX);
        run_seq(20, -1);
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(1, 20);
            fill_rand(len > SEQ_MAX ? SEQ_MAX : len);
            run_seq(len, -1);
        end
        for (int a = 0; a < SEQ_MAX; a++) if (mw[a]) rd_chk(LEN_W'(a), mh[a], mc[a]);
        rd_chk(LEN_W'($urandom_range(SEQ_MAX, 31)), 0, 0);

        i_start = 1'b1;
        i_seq_len = 5'd5;
        @(negedge clk);
        i_start = 1'b0;
        i_x_valid = 1'b1;
        @(negedge clk);
        i_x_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_cell_en", o_cell_en, 0);
        chk("mrst_cx", o_c_x == '0, 1);
        chk("mrst_h", o_h == '0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_idle", o_x_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
